// File: rtl/kamikaze_pkg.sv
// rtl/kamikaze_pkg.sv - shared encodings for the instruction memory prefetch responder
package kamikaze_pkg;

  localparam int          TAG_W = 30;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef logic [TAG_W-1:0] tag_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/kamikaze_prefetch_buf.sv
// rtl/kamikaze_prefetch_buf.sv - two-entry tag/data store with hit compare, LRU victim and invalidate-all
module kamikaze_prefetch_buf
  import kamikaze_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  tag_t        key,
  input  tag_t        probe,
  input  logic        inval,
  input  logic        wr_en,
  input  tag_t        wr_tag,
  input  logic [31:0] wr_data,
  output logic        hit,
  output logic [31:0] hit_data,
  output logic        probe_hit,
  output logic        victim
);

  logic [1:0]  valid;
  tag_t        tag  [2];
  logic [31:0] data [2];
  logic        lru;
  logic [1:0]  hit_vec;
  logic [1:0]  probe_vec;
  logic        hit_idx;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      hit_vec[i]   = valid[i] && (tag[i] == key);
      probe_vec[i] = valid[i] && (tag[i] == probe);
    end
  end

  assign hit       = |hit_vec;
  assign hit_idx   = hit_vec[1];
  assign hit_data  = data[hit_idx];
  assign probe_hit = |probe_vec;
  // Never evict the word the fetcher is currently consuming.
  assign victim    = hit ? ~hit_idx : lru;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid <= '0;
      lru   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        tag[i]  <= '0;
        data[i] <= '0;
      end
    end else if (inval) begin
      valid <= '0;
    end else begin
      if (wr_en) begin
        valid[victim] <= 1'b1;
        tag[victim]   <= wr_tag;
        data[victim]  <= wr_data;
      end
      if (hit) lru <= ~hit_idx;
    end
  end

endmodule

// File: rtl/kamikaze_imem_prefetch.sv
// rtl/kamikaze_imem_prefetch.sv - fetch responder serving words from a 2-entry prefetch buffer over a req/gnt/rvalid bus
module kamikaze_imem_prefetch
  import kamikaze_pkg::*;
#(
  parameter bit          PREFETCH_EN     = 1'b1,
  parameter logic [31:0] RESET_ADDR_BASE = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  output logic [31:0] ir_o,
  output logic        ready_o,
  input  logic        flush_i,
  output logic        bus_req_o,
  output logic [31:0] bus_addr_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i
);

  state_t      state, state_d;
  tag_t        target, target_d;
  logic        drop, drop_d;
  tag_t        key, next_key;
  logic        hit, probe_hit, victim;
  logic [31:0] hit_data;
  logic        fill_write, fwd;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^addr_i[1:0];
  assign key        = addr_i[31:2];
  assign next_key   = key + tag_t'(1);
  assign fill_write = (state == ST_WAIT) && bus_rvalid_i && !drop && !flush_i;
  assign fwd        = fill_write && (target == key);

  kamikaze_prefetch_buf u_buf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .key       (key),
    .probe     (next_key),
    .inval     (flush_i),
    .wr_en     (fill_write),
    .wr_tag    (target),
    .wr_data   (bus_rdata_i),
    .hit       (hit),
    .hit_data  (hit_data),
    .probe_hit (probe_hit),
    .victim    (victim)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= ST_IDLE;
      target <= '0;
      drop   <= 1'b0;
    end else begin
      state  <= state_d;
      target <= target_d;
      drop   <= drop_d;
    end
  end

  always_comb begin
    state_d  = state;
    target_d = target;
    drop_d   = drop;
    case (state)
      ST_IDLE: begin
        if (!flush_i) begin
          if (!hit) begin
            target_d = key;
            state_d  = ST_REQ;
          end else if (PREFETCH_EN && !probe_hit) begin
            target_d = next_key;
            state_d  = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        // A granted request cannot be withdrawn, so a flush then poisons the response.
        if (bus_gnt_i) begin
          state_d = ST_WAIT;
          drop_d  = flush_i;
        end else if (flush_i) begin
          state_d = ST_IDLE;
        end else if (!hit && (key != target)) begin
          target_d = key;
        end
      end
      ST_WAIT: begin
        if (bus_rvalid_i) begin
          state_d = ST_IDLE;
          drop_d  = 1'b0;
        end else if (flush_i) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus_req_o  = (state == ST_REQ);
    bus_addr_o = RESET_ADDR_BASE;
    if (state != ST_IDLE) bus_addr_o = {target, 2'b00};
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ready_o <= 1'b0;
      ir_o    <= NOP;
    end else if (flush_i) begin
      ready_o <= 1'b0;
    end else if (fwd) begin
      ready_o <= 1'b1;
      ir_o    <= bus_rdata_i;
    end else if (hit) begin
      ready_o <= 1'b1;
      ir_o    <= hit_data;
    end else begin
      ready_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_kamikaze_imem_prefetch.sv
// tb/tb_kamikaze_imem_prefetch.sv - directed self-checking bench for kamikaze_imem_prefetch
module tb_kamikaze_imem_prefetch;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] NOPW = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] ir;
  logic        ready;
  logic        flush = 1'b0;
  logic        req;
  logic [31:0] baddr;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;

  int checks = 0;
  int passed = 0;

  kamikaze_imem_prefetch #(
    .PREFETCH_EN     (1'b1),
    .RESET_ADDR_BASE (BASE)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .addr_i       (addr),
    .ir_o         (ir),
    .ready_o      (ready),
    .flush_i      (flush),
    .bus_req_o    (req),
    .bus_addr_o   (baddr),
    .bus_gnt_i    (gnt),
    .bus_rvalid_i (rvalid),
    .bus_rdata_i  (rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; addr = 32'h100; flush = 0; gnt = 0; rvalid = 0;
    step(); step();
    checks++; if (ready !== 1'b0) $display("FAIL reset_ready: got %0b want 0", ready); else passed++;
    checks++; if (ir !== NOPW) $display("FAIL reset_ir: got %h want %h", ir, NOPW); else passed++;
    checks++; if (req !== 1'b0) $display("FAIL reset_req: got %0b want 0", req); else passed++;
    checks++; if (baddr !== BASE) $display("FAIL reset_baddr: got %h want %h", baddr, BASE); else passed++;
    rst = 1'b1;
  endtask

  task automatic test_cold_miss();
    step();
    checks++; if (req !== 1'b1 || baddr !== 32'h100) $display("FAIL cold_req: got req=%0b addr=%h want 1/00000100", req, baddr); else passed++;
    step();
    checks++; if (req !== 1'b1 || baddr !== 32'h100) $display("FAIL cold_req_held: got req=%0b addr=%h want 1/00000100", req, baddr); else passed++;
    gnt = 1; step(); gnt = 0;
    checks++; if (req !== 1'b0) $display("FAIL cold_req_drop: got %0b want 0", req); else passed++;
    step();
    checks++; if (ready !== 1'b0) $display("FAIL cold_wait_ready: got %0b want 0", ready); else passed++;
    rvalid = 1; rdata = 32'hDEAD_BEEF; step(); rvalid = 0;
    checks++; if (ready !== 1'b1 || ir !== 32'hDEAD_BEEF) $display("FAIL cold_data: got ready=%0b ir=%h want 1/deadbeef", ready, ir); else passed++;
    step();
    checks++; if (req !== 1'b1 || baddr !== 32'h104) $display("FAIL cold_prefetch: got req=%0b addr=%h want 1/00000104", req, baddr); else passed++;
    checks++; if (ready !== 1'b1) $display("FAIL cold_hit_ready: got %0b want 1", ready); else passed++;
  endtask

  task automatic test_streaming();
    gnt = 1; step(); gnt = 0;
    rvalid = 1; rdata = 32'hCAFE_0104; step(); rvalid = 0;
    checks++; if (ready !== 1'b1 || ir !== 32'hDEAD_BEEF) $display("FAIL stream_100: got ready=%0b ir=%h want 1/deadbeef", ready, ir); else passed++;
    addr = 32'h104; step();
    checks++; if (ready !== 1'b1 || ir !== 32'hCAFE_0104) $display("FAIL stream_104: got ready=%0b ir=%h want 1/cafe0104", ready, ir); else passed++;
    checks++; if (req !== 1'b1 || baddr !== 32'h108) $display("FAIL stream_pf108: got req=%0b addr=%h want 1/00000108", req, baddr); else passed++;
    gnt = 1; step(); gnt = 0;
    rvalid = 1; rdata = 32'h0000_0108; step(); rvalid = 0;
    checks++; if (ready !== 1'b1 || ir !== 32'hCAFE_0104) $display("FAIL stream_fill108: got ready=%0b ir=%h want 1/cafe0104", ready, ir); else passed++;
  endtask

  task automatic test_misaligned();
    addr = 32'h106; step();
    checks++; if (ready !== 1'b1 || ir !== 32'hCAFE_0104) $display("FAIL misaligned_hit: got ready=%0b ir=%h want 1/cafe0104", ready, ir); else passed++;
    step();
    checks++; if (req !== 1'b0 || baddr !== BASE) $display("FAIL misaligned_nobus: got req=%0b addr=%h want 0/%h", req, baddr, BASE); else passed++;
    addr = 32'h108; step();
    checks++; if (ready !== 1'b1 || ir !== 32'h0000_0108) $display("FAIL stream_108: got ready=%0b ir=%h want 1/00000108", ready, ir); else passed++;
    checks++; if (req !== 1'b1 || baddr !== 32'h10C) $display("FAIL stream_pf10c: got req=%0b addr=%h want 1/0000010c", req, baddr); else passed++;
  endtask

  task automatic test_preempt_and_flush_wait();
    addr = 32'h200; step();
    checks++; if (req !== 1'b1 || baddr !== 32'h200) $display("FAIL preempt_addr: got req=%0b addr=%h want 1/00000200", req, baddr); else passed++;
    gnt = 1; step(); gnt = 0;
    flush = 1; addr = 32'h300; step(); flush = 0;
    checks++; if (ready !== 1'b0) $display("FAIL flushwait_ready: got %0b want 0", ready); else passed++;
    step();
    rvalid = 1; rdata = 32'hBAD0_0200; step(); rvalid = 0;
    checks++; if (ready !== 1'b0) $display("FAIL flushwait_discard: got %0b want 0", ready); else passed++;
    step();
    checks++; if (req !== 1'b1 || baddr !== 32'h300) $display("FAIL flushwait_next: got req=%0b addr=%h want 1/00000300", req, baddr); else passed++;
    checks++; if (ready !== 1'b0) $display("FAIL flushwait_stale: got %0b want 0", ready); else passed++;
    gnt = 1; step(); gnt = 0;
    rvalid = 1; rdata = 32'h0300_AAAA; step(); rvalid = 0;
    checks++; if (ready !== 1'b1 || ir !== 32'h0300_AAAA) $display("FAIL flushwait_data: got ready=%0b ir=%h want 1/0300aaaa", ready, ir); else passed++;
  endtask

  task automatic test_flush_rvalid_hit();
    step();
    checks++; if (req !== 1'b1 || baddr !== 32'h304) $display("FAIL fhit_pf304: got req=%0b addr=%h want 1/00000304", req, baddr); else passed++;
    gnt = 1; step(); gnt = 0;
    flush = 1; rvalid = 1; rdata = 32'h0304_BBBB; step(); flush = 0; rvalid = 0;
    checks++; if (ready !== 1'b0) $display("FAIL fhit_ready: got %0b want 0", ready); else passed++;
    checks++; if (req !== 1'b0) $display("FAIL fhit_noreq: got %0b want 0", req); else passed++;
    step();
    checks++; if (req !== 1'b1 || baddr !== 32'h300 || ready !== 1'b0) $display("FAIL fhit_invalid: got req=%0b addr=%h ready=%0b want 1/00000300/0", req, baddr, ready); else passed++;
  endtask

  task automatic test_wrap();
    rst = 1'b0; addr = 32'hFFFF_FFFC; flush = 0; gnt = 0; rvalid = 0;
    step(); rst = 1'b1;
    step();
    checks++; if (req !== 1'b1 || baddr !== 32'hFFFF_FFFC) $display("FAIL wrap_req: got req=%0b addr=%h want 1/fffffffc", req, baddr); else passed++;
    gnt = 1; step(); gnt = 0;
    rvalid = 1; rdata = 32'h1111_FFFC; step(); rvalid = 0;
    checks++; if (ready !== 1'b1 || ir !== 32'h1111_FFFC) $display("FAIL wrap_data: got ready=%0b ir=%h want 1/1111fffc", ready, ir); else passed++;
    step();
    checks++; if (req !== 1'b1 || baddr !== 32'h0000_0000) $display("FAIL wrap_pf0: got req=%0b addr=%h want 1/00000000", req, baddr); else passed++;
    gnt = 1; step(); gnt = 0;
    rvalid = 1; rdata = 32'h2222_0000; step(); rvalid = 0;
    addr = 32'h0; step();
    checks++; if (ready !== 1'b1 || ir !== 32'h2222_0000) $display("FAIL wrap_hit0: got ready=%0b ir=%h want 1/22220000", ready, ir); else passed++;
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_streaming();
    test_misaligned();
    test_preempt_and_flush_wait();
    test_flush_rvalid_hit();
    test_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
